// File: rtl/column_feeder_5rows_pkg.sv
// Shared types for the 5-row column feeder: FSM states and line-ring pointer width.
package column_feeder_5rows_pkg;
  localparam int PTR_W    = 2;
  localparam int NUM_RAMS = 1 << PTR_W;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN} state_t;
endpackage

// File: rtl/column_feeder_5rows_line_ram.sv
// Single-clock line RAM. The read register samples the old word, so a write to the
// same address in the same cycle is seen only by the next read.
module line_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 640,
  parameter int AW         = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // only the read register is cleared; array contents survive reset
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/column_feeder_5rows.sv
// Turns a pixel stream into 5-pixel vertical columns using a ring of 4 line RAMs.
// Optional COLUMN_FEEDER_ERR_CNT_EN adds a saturating line-fault/restart counter o_err_cnt.
module column_feeder_5rows
  import column_feeder_5rows_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] o_num_0,
  output logic [DATA_WIDTH-1:0] o_num_1,
  output logic [DATA_WIDTH-1:0] o_num_2,
  output logic [DATA_WIDTH-1:0] o_num_3,
  output logic [DATA_WIDTH-1:0] o_num_4,
`ifdef COLUMN_FEEDER_ERR_CNT_EN
  output logic [15:0]           o_err_cnt,
`endif
  output logic                  o_valid,
  output logic                  o_sof,
  output logic                  o_eol
);
  localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [AW-1:0]    LAST_COL = AW'(IMG_WIDTH - 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_RAMS - 1);

  state_t                 state, state_nx;
  logic [AW-1:0]          col_cnt, col_nx, addr;
  logic [PTR_W-1:0]       wptr, wptr_nx, wsel, rd_ptr;
  logic                   accept, restart, eol, store, emit, sof_pend, sof_pend_nx;
  logic [DATA_WIDTH-1:0]  live;
  logic [NUM_RAMS-1:0]    we;
  logic [NUM_RAMS-1:0][DATA_WIDTH-1:0] rd;

  assign s_axis_tready = ~i_reset;
  assign accept  = s_axis_tvalid & s_axis_tready;
  assign restart = accept & s_axis_tuser;
  assign eol     = accept & (s_axis_tlast | (col_cnt == LAST_COL));

  always_comb begin
    state_nx    = state;
    col_nx      = col_cnt;
    wptr_nx     = wptr;
    sof_pend_nx = sof_pend;
    store       = 1'b0;
    emit        = 1'b0;
    if (restart) begin
      // a start-of-frame beat is row 0 col 0 regardless of where we were
      store       = 1'b1;
      state_nx    = S_FILL;
      sof_pend_nx = 1'b0;
      wptr_nx     = PTR_W'(s_axis_tlast);
      col_nx      = s_axis_tlast ? '0 : AW'(1);
    end else if (accept && state != S_IDLE) begin
      store = 1'b1;
      emit  = (state == S_RUN);
      if (emit) sof_pend_nx = 1'b0;
      if (eol) begin
        col_nx  = '0;
        wptr_nx = wptr + PTR_W'(1);
        if (state == S_FILL && wptr == LAST_PTR) begin
          state_nx    = S_RUN;
          sof_pend_nx = 1'b1;
        end
      end else begin
        col_nx = col_cnt + AW'(1);
      end
    end
  end

  assign addr = restart ? '0 : col_cnt;
  assign wsel = restart ? '0 : wptr;

  for (genvar i = 0; i < NUM_RAMS; i++) begin : g_ram
    assign we[i] = store & (wsel == PTR_W'(i));
    line_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH), .AW(AW)) u_ram (
      .clk(i_clk), .rst(i_reset), .we(we[i]), .re(emit),
      .addr(addr), .wdata(s_axis_tdata), .rdata(rd[i])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= S_IDLE;
      col_cnt  <= '0;
      wptr     <= '0;
      sof_pend <= 1'b0;
      o_valid  <= 1'b0;
      o_sof    <= 1'b0;
      o_eol    <= 1'b0;
      live     <= '0;
      rd_ptr   <= '0;
    end else begin
      state    <= state_nx;
      col_cnt  <= col_nx;
      wptr     <= wptr_nx;
      sof_pend <= sof_pend_nx;
      o_valid  <= emit;
      o_sof    <= emit & sof_pend;
      o_eol    <= emit & eol;
      if (emit) begin
        live   <= s_axis_tdata;
        rd_ptr <= wptr;
      end
    end
  end

  // the RAM being written holds the oldest row; the ring order follows from it
  assign o_num_0 = rd[rd_ptr];
  assign o_num_1 = rd[rd_ptr + PTR_W'(1)];
  assign o_num_2 = rd[rd_ptr + PTR_W'(2)];
  assign o_num_3 = rd[rd_ptr + PTR_W'(3)];
  assign o_num_4 = live;

`ifdef COLUMN_FEEDER_ERR_CNT_EN
  logic err_inc;
  assign err_inc = accept && state != S_IDLE &&
                   (s_axis_tuser || (s_axis_tlast != (col_cnt == LAST_COL)));

  always_ff @(posedge i_clk) begin
    if (i_reset)                          o_err_cnt <= '0;
    else if (err_inc && ~&o_err_cnt)      o_err_cnt <= o_err_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_column_feeder_5rows.sv
// Directed bench for column_feeder_5rows with a frame-level reference model.
module tb_column_feeder_5rows;
  localparam int DW = 8;
  localparam int W  = 4;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tuser, s_axis_tlast;
  logic [DW-1:0] o_num_0, o_num_1, o_num_2, o_num_3, o_num_4;
  logic          o_valid, o_sof, o_eol;
`ifdef COLUMN_FEEDER_ERR_CNT_EN
  logic [15:0]   o_err_cnt;
`endif

  always #5 i_clk = ~i_clk;

  column_feeder_5rows #(.DATA_WIDTH(DW), .IMG_WIDTH(W)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
    .o_num_0(o_num_0), .o_num_1(o_num_1), .o_num_2(o_num_2), .o_num_3(o_num_3), .o_num_4(o_num_4),
`ifdef COLUMN_FEEDER_ERR_CNT_EN
    .o_err_cnt(o_err_cnt),
`endif
    .o_valid(o_valid), .o_sof(o_sof), .o_eol(o_eol)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: frame rows, 4 stored lines indexed by frame row mod 4
  int            mst;            // 0 waiting for sof, 1 filling, 2 running
  int            frow, mcol, exp_err;
  logic [DW-1:0] lines [4][W];
  logic [DW-1:0] exp_num [5];
  logic          exp_valid, exp_sof, exp_eol, sof_pend;
  logic          armed = 1'b0;

  always @(posedge i_clk) begin : model
    int  slot;
    bit  e;
    if (i_reset) begin
      armed = 1'b1; mst = 0; frow = 0; mcol = 0; exp_err = 0;
      exp_valid = 0; exp_sof = 0; exp_eol = 0; sof_pend = 0;
      for (int k = 0; k < 5; k++) exp_num[k] = '0;
    end else if (armed) begin
      exp_valid = 0; exp_sof = 0; exp_eol = 0;
      if (s_axis_tvalid) begin
        e = s_axis_tlast || (mcol == W - 1);
        if (s_axis_tuser) begin
          if (mst != 0) exp_err++;
          mst = 1; sof_pend = 0;
          lines[0][0] = s_axis_tdata;
          frow = s_axis_tlast ? 1 : 0;
          mcol = s_axis_tlast ? 0 : 1;
        end else if (mst != 0) begin
          slot = frow % 4;
          if (mst == 2) begin
            for (int k = 0; k < 4; k++) exp_num[k] = lines[(slot + k) % 4][mcol];
            exp_num[4] = s_axis_tdata;
            exp_valid = 1; exp_sof = sof_pend; exp_eol = e; sof_pend = 0;
          end
          lines[slot][mcol] = s_axis_tdata;
          if ((s_axis_tlast && mcol < W - 1) || (!s_axis_tlast && mcol == W - 1)) exp_err++;
          if (e) begin
            mcol = 0; frow++;
            if (mst == 1 && frow == 4) begin mst = 2; sof_pend = 1; end
          end else mcol++;
        end
      end
    end
  end

  always @(negedge i_clk) begin : compare
    if (armed) begin
      check("tready", s_axis_tready, !i_reset);
      check("valid", o_valid, exp_valid);
      check("sof", o_sof, exp_sof);
      check("eol", o_eol, exp_eol);
      check("num0", o_num_0, exp_num[0]);
      check("num1", o_num_1, exp_num[1]);
      check("num2", o_num_2, exp_num[2]);
      check("num3", o_num_3, exp_num[3]);
      check("num4", o_num_4, exp_num[4]);
`ifdef COLUMN_FEEDER_ERR_CNT_EN
      check("err_cnt", o_err_cnt, exp_err);
`endif
    end
  end

  function automatic logic [DW-1:0] pix(input int r, input int c);
    return DW'(r * 16 + c);
  endfunction

  task automatic drive(input logic [DW-1:0] d, input logic v, input logic u, input logic l);
    s_axis_tdata = d; s_axis_tvalid = v; s_axis_tuser = u; s_axis_tlast = l;
    @(posedge i_clk);
    #1;
  endtask

  task automatic row(input int r, input int c0, input int c1, input bit lst, input bit sof);
    for (int c = c0; c <= c1; c++) drive(pix(r, c), 1'b1, sof && c == c0, lst && c == c1);
  endtask

  task automatic lit_col(input string name, input logic [DW-1:0] a, b, c, d, e);
    check({name, "_n0"}, o_num_0, a);
    check({name, "_n1"}, o_num_1, b);
    check({name, "_n2"}, o_num_2, c);
    check({name, "_n3"}, o_num_3, d);
    check({name, "_n4"}, o_num_4, e);
  endtask

  initial begin
    i_reset = 1'b1;
    s_axis_tdata = '0; s_axis_tvalid = 0; s_axis_tuser = 0; s_axis_tlast = 0;
    drive(0, 0, 0, 0);
    drive(8'h99, 1, 1, 0);
    check("rst_valid", o_valid, 0);
    check("rst_ready", s_axis_tready, 0);
    lit_col("rst", 0, 0, 0, 0, 0);
    i_reset = 1'b0;
    #1 check("ready_after_rst", s_axis_tready, 1);

    drive(8'h55, 1, 0, 0);
    check("idle_discard", o_valid, 0);

    // fill rows 0..3, first column on row 4
    for (int r = 0; r < 4; r++) row(r, 0, W - 1, 1, r == 0);
    check("fill_no_valid", o_valid, 0);
    drive(pix(4, 0), 1, 0, 0);
    check("first_valid", o_valid, 1);
    check("first_sof", o_sof, 1);
    lit_col("first", 8'h00, 8'h10, 8'h20, 8'h30, 8'h40);
    row(4, 1, W - 1, 1, 0);
    row(5, 0, W - 1, 1, 0);
    row(6, 0, W - 1, 1, 0);
    lit_col("ring", 8'h23, 8'h33, 8'h43, 8'h53, 8'h63);
    check("ring_eol", o_eol, 1);
    check("ring_sof", o_sof, 0);

    // gapped valid
    drive(pix(7, 0), 1, 0, 0);
    check("gap_v1", o_valid, 1);
    drive(0, 0, 0, 0);
    check("gap_v0", o_valid, 0);
    check("gap_hold4", o_num_4, 8'h70);
    check("gap_hold0", o_num_0, 8'h30);
    drive(pix(7, 1), 1, 0, 0);
    check("gap_v1b", o_valid, 1);
    drive(0, 0, 0, 0);
    check("gap_v0b", o_valid, 0);
    row(7, 2, W - 1, 1, 0);

    // early tlast on row 8, missing tlast on row 10
    row(8, 0, 1, 1, 0);
    drive(pix(9, 0), 1, 0, 0);
    lit_col("early", 8'h50, 8'h60, 8'h70, 8'h80, 8'h90);
    row(9, 1, W - 1, 1, 0);
    row(10, 0, W - 1, 0, 0);
    check("implicit_eol", o_eol, 1);
    drive(pix(11, 0), 1, 0, 0);
    lit_col("wrap", 8'h70, 8'h80, 8'h90, 8'hA0, 8'hB0);
    row(11, 1, W - 1, 1, 0);
    row(12, 0, 2, 0, 0);
    check("stale_tail", o_num_0, 8'h42);
    row(12, 3, 3, 1, 0);
`ifdef COLUMN_FEEDER_ERR_CNT_EN
    check("err_faults", o_err_cnt, 2);
`endif

    // restart mid-line
    row(13, 0, 1, 0, 0);
    drive(pix(0, 0), 1, 1, 0);
    check("restart_no_valid", o_valid, 0);
    row(0, 1, W - 1, 1, 0);
    for (int r = 1; r < 4; r++) row(r, 0, W - 1, 1, 0);
    check("restart_fill", o_valid, 0);
    drive(pix(4, 0), 1, 0, 0);
    check("restart_sof", o_sof, 1);
    lit_col("restart", 8'h00, 8'h10, 8'h20, 8'h30, 8'h40);
`ifdef COLUMN_FEEDER_ERR_CNT_EN
    check("err_restart", o_err_cnt, 3);
`endif

    // reset in S_RUN
    drive(pix(4, 1), 1, 0, 0);
    i_reset = 1'b1;
    drive(pix(4, 2), 1, 0, 0);
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_sof", o_sof, 0);
    check("mid_rst_eol", o_eol, 0);
    check("mid_rst_ready", s_axis_tready, 0);
    lit_col("mid_rst", 0, 0, 0, 0, 0);
    i_reset = 1'b0;
    row(5, 0, W - 1, 1, 0);
    check("post_rst_no_valid", o_valid, 0);
    row(6, 0, W - 1, 1, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/column_feeder_5rows.md
COLUMN_FEEDER_5ROWS -- requirements
Module: column_feeder_5rows

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named as follows:
 - i_clk  input  1  rising-edge clock.
 - i_reset  input  1  synchronous, active-high reset.
REQ-002 The block SHALL have these parameters (name, default, meaning):
 - DATA_WIDTH, 8, pixel width.
 - IMG_WIDTH, 640, pixels per line; fixed; minimum 2.
REQ-003 The block SHALL have these signals (name, direction, width, meaning):
 - s_axis_tdata  input  DATA_WIDTH  pixel in.
 - s_axis_tvalid  input  1  beat valid.
 - s_axis_tready  output  1  beat ready.
 - s_axis_tuser  input  1  start of frame, on the first pixel.
 - s_axis_tlast  input  1  end of line.
 - o_num_0..o_num_4  output  DATA_WIDTH each  one 5-pixel column, row y-4 (o_num_0) down to row y (o_num_4); drives sorter i_num_0..4 directly.
 - o_valid  output  1  column valid.
 - o_sof  output  1  first column of the first window row of a frame.
 - o_eol  output  1  last column of a line.

Function
REQ-004 An input beat SHALL be accepted when s_axis_tvalid and s_axis_tready are both high; s_axis_tready SHALL be 1 in every state when not in reset.
REQ-005 The FSM SHALL have three states:
 - S_IDLE: discard beats until an accepted beat has tuser=1; that beat is stored as row 0, col 0, then go to S_FILL.
 - S_FILL: store rows 0..3 with no output; the end of row 3 goes to S_RUN.
 - S_RUN: each accepted beat emits one column.
REQ-006 Storage SHALL be 4 line RAMs of IMG_WIDTH x DATA_WIDTH, used as a ring; a 2-bit write pointer advances at each end of line.
REQ-007 RAM reads SHALL be read-before-write at the same address, so the new pixel overwrites row y-4 in the same cycle it is read.
REQ-008 Latency SHALL be exactly 1 cycle: o_valid and the column appear on the cycle after the accepted beat; the live pixel is registered once to align with RAM read data.
REQ-009 The ring rotation SHALL be applied so that o_num_0 is always the oldest row and o_num_4 the live pixel.
REQ-010 In cycles with no accepted beat, o_valid SHALL be 0 and o_num_* SHALL hold their values.
REQ-011 col_cnt SHALL run 0..IMG_WIDTH-1.
REQ-012 End of line SHALL be an accepted beat with tlast=1, or with col_cnt=IMG_WIDTH-1, whichever comes first; col_cnt then returns to 0 and the row advances.
REQ-013 An early tlast (col_cnt<IMG_WIDTH-1) SHALL end the line, and the unwritten RAM tail keeps stale data.
REQ-014 A missing tlast at col_cnt=IMG_WIDTH-1 SHALL wrap col_cnt to 0 as an implicit end of line.
REQ-015 o_eol SHALL be the registered end-of-line condition for beats emitted in S_RUN.
REQ-016 o_sof SHALL be 1 only with the first o_valid after S_FILL to S_RUN.
REQ-017 A beat with tuser=1 in S_FILL or S_RUN SHALL restart the frame: the beat is stored as row 0, col 0, the write pointer is reset, the state goes to S_FILL, and that beat emits no column.
REQ-018 A tuser=1 beat that also has tlast=1 SHALL be a restart plus end of line.
REQ-019 Frame height SHALL not be tracked; S_RUN persists until reset or a new tuser.

Reset
REQ-020 While i_reset=1: state S_IDLE, col_cnt=0, write pointer=0, s_axis_tready=0, o_valid=0, o_sof=0, o_eol=0, o_num_0..4=0.
REQ-021 RAM contents SHALL NOT be reset.
REQ-022 On the first cycle after i_reset falls, s_axis_tready=1.
REQ-023 Reset mid-line or mid-frame SHALL abandon the frame; the next frame needs tuser.

Configuration
REQ-024 Macro COLUMN_FEEDER_ERR_CNT_EN defined: add output o_err_cnt, 16 bits, reset 0.
 - It increments (saturating at 0xFFFF) on each early tlast or missing tlast.
 - It increments on a tuser restart while in S_FILL or S_RUN.
REQ-025 Macro COLUMN_FEEDER_ERR_CNT_EN undefined: the port and logic SHALL be absent; all other behaviour is identical.

Structure
REQ-026 A shared package SHALL hold the FSM state enum (S_IDLE, S_FILL, S_RUN) and the ring-pointer width constant.
REQ-027 A single sub-module line_ram SHALL be instantiated 4 times; it is a single-clock, read-before-write RAM with 1-cycle synchronous read.

Verification
Bench setup: IMG_WIDTH=4, pixel value = row*16+col.
REQ-028 Fill test: stream rows 0..4 without gaps -> no o_valid during rows 0..3; the cycle after pixel 0x40 -> o_valid=1, o_sof=1, o_num_0..4 = 0x00,0x10,0x20,0x30,0x40.
REQ-029 Ring rotation: continue with rows 5 and 6 -> the column for 0x63 = 0x23,0x33,0x43,0x53,0x63, o_eol=1, o_sof=0.
REQ-030 Gapped valid: tvalid toggling 1,0,1,0 in S_RUN -> o_valid toggles with a 1-cycle lag and o_num_* hold during gaps.
REQ-031 Restart: tuser=1 on row 6 col 2 -> no o_valid for the next 4 lines; o_err_cnt=1 when COLUMN_FEEDER_ERR_CNT_EN is defined.
REQ-032 Line faults:
 - tlast at col 1 -> the next beat is col 0 of the next row; o_err_cnt +1.
 - No tlast at col 3 -> implicit wrap; o_err_cnt +1.
REQ-033 Reset mid-S_RUN: assert i_reset for 1 cycle -> all outputs 0 that cycle, and tuser-less beats afterwards produce no o_valid.
